csr_exec_unit: RTL and testbench

Executes Zicsr instructions (CSRRW/CSRRS/CSRRC and their immediate forms) on behalf of the core pipeline. Drives the CSR register file's read and write ports as the initiating side. Accepts one CSR operation per valid/ready handshake, performs a read-modify-write sequence, and returns the old CSR value for writeback to `rd`. Sits between decode/execute and the CSR register file.

---
 rtl/csr_exec_unit.sv | 149 ++++++++++++++
 tb/tb_csr_exec_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/csr_exec_unit.sv
// Zicsr execution unit: one read-modify-write of a CSR per accepted request.
// Returns the old CSR value and drives the register file's read and write ports.
module csr_exec_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_funct3,
  input  logic [11:0] in_csr_addr,
  input  logic [31:0] in_rs1_val,
  input  logic [4:0]  in_rs1_idx,
  input  logic [4:0]  in_rd_idx,
  output logic [11:0] csr_r_addr,
  input  logic [31:0] csr_r_val,
  output logic [11:0] csr_w_addr,
  output logic [31:0] csr_w_val,
  output logic        w_enable,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rd_idx,
  output logic [31:0] out_rd_val,
  output logic        out_illegal,
  output logic [31:0] op_count
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state, next_state;
  logic [2:0]  funct3_q;
  logic [11:0] addr_q;
  logic [31:0] rs1_val_q;
  logic [4:0]  rs1_idx_q;
  logic [4:0]  rd_idx_q;
  logic [31:0] old_q;
  logic [31:0] new_q;
  logic        wr_req_q;
  logic        illegal_q;

  logic [31:0] src;
  logic [31:0] new_val;
  logic        wr_req;
  logic        illegal;

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Immediate forms take zimm from the rs1 field; set/clear with a zero source never writes.
  always_comb begin
    src     = funct3_q[2] ? {27'b0, rs1_idx_q} : rs1_val_q;
    new_val = csr_r_val;
    wr_req  = 1'b0;
    case (funct3_q[1:0])
      2'b01: begin
        new_val = src;
        wr_req  = 1'b1;
      end
      2'b10: begin
        new_val = csr_r_val | src;
        wr_req  = (rs1_idx_q != 5'd0);
      end
      2'b11: begin
        new_val = csr_r_val & ~src;
        wr_req  = (rs1_idx_q != 5'd0);
      end
      default: begin
        new_val = csr_r_val;
        wr_req  = 1'b0;
      end
    endcase
    illegal = (funct3_q[1:0] == 2'b00) || (wr_req && (addr_q[11:10] == 2'b11));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      funct3_q  <= '0;
      addr_q    <= '0;
      rs1_val_q <= '0;
      rs1_idx_q <= '0;
      rd_idx_q  <= '0;
      old_q     <= '0;
      new_q     <= '0;
      wr_req_q  <= 1'b0;
      illegal_q <= 1'b0;
      op_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            funct3_q  <= in_funct3;
            addr_q    <= in_csr_addr;
            rs1_val_q <= in_rs1_val;
            rs1_idx_q <= in_rs1_idx;
            rd_idx_q  <= in_rd_idx;
          end
        end
        READ: begin
          old_q     <= csr_r_val;
          new_q     <= new_val;
          wr_req_q  <= wr_req;
          illegal_q <= illegal;
        end
        RESP: begin
          if (out_ready && !illegal_q) op_count <= op_count + 32'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state  = state;
    in_ready    = 1'b0;
    csr_r_addr  = '0;
    csr_w_addr  = '0;
    csr_w_val   = '0;
    w_enable    = 1'b0;
    out_valid   = 1'b0;
    out_rd_idx  = '0;
    out_rd_val  = '0;
    out_illegal = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = READ;
      end
      READ: begin
        csr_r_addr = addr_q;
        next_state = WRITE;
      end
      WRITE: begin
        w_enable   = wr_req_q & ~illegal_q;
        csr_w_addr = addr_q;
        csr_w_val  = new_q;
        next_state = RESP;
      end
      RESP: begin
        out_valid   = 1'b1;
        out_rd_idx  = rd_idx_q;
        out_rd_val  = illegal_q ? 32'd0 : old_q;
        out_illegal = illegal_q;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_exec_unit.sv
// Directed testbench for csr_exec_unit with a behavioural CSR register file
// and hand-computed expected values.
module tb_csr_exec_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_funct3 = '0;
  logic [11:0] in_csr_addr = '0;
  logic [31:0] in_rs1_val = '0;
  logic [4:0]  in_rs1_idx = '0;
  logic [4:0]  in_rd_idx = '0;
  logic [11:0] csr_r_addr;
  logic [31:0] csr_r_val;
  logic [11:0] csr_w_addr;
  logic [31:0] csr_w_val;
  logic        w_enable;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  out_rd_idx;
  logic [31:0] out_rd_val;
  logic        out_illegal;
  logic [31:0] op_count;

  logic [31:0] csr_mem [0:4095];
  logic        pre_en = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [31:0] pre_val = '0;
  int          w_count = 0;
  int          checks = 0;
  int          errors = 0;
  int          wc_snap;

  csr_exec_unit dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
    .in_csr_addr(in_csr_addr), .in_rs1_val(in_rs1_val), .in_rs1_idx(in_rs1_idx),
    .in_rd_idx(in_rd_idx), .csr_r_addr(csr_r_addr), .csr_r_val(csr_r_val),
    .csr_w_addr(csr_w_addr), .csr_w_val(csr_w_val), .w_enable(w_enable),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd_idx(out_rd_idx),
    .out_rd_val(out_rd_val), .out_illegal(out_illegal), .op_count(op_count)
  );

  always #5 clock = ~clock;

  assign csr_r_val = csr_mem[csr_r_addr];

  // Register-file model: DUT writes win over bench preloads.
  always @(posedge clock) begin
    if (w_enable) begin
      csr_mem[csr_w_addr] <= csr_w_val;
      w_count <= w_count + 1;
    end else if (pre_en) begin
      csr_mem[pre_addr] <= pre_val;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic preload(input logic [11:0] addr, input logic [31:0] val);
    pre_en = 1'b1;
    pre_addr = addr;
    pre_val = val;
    @(posedge clock); #1;
    pre_en = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [2:0] f3, input logic [11:0] addr,
                                input logic [31:0] rs1v, input logic [4:0] rs1i,
                                input logic [4:0] rd, input logic exp_we,
                                input logic [31:0] exp_wval, input logic [31:0] exp_rdval,
                                input logic exp_ill, input int hold);
    int waited = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clock); #1;
      waited++;
    end
    check_output("accept_ready", in_ready, 1);
    in_valid = 1'b1;
    in_funct3 = f3;
    in_csr_addr = addr;
    in_rs1_val = rs1v;
    in_rs1_idx = rs1i;
    in_rd_idx = rd;
    out_ready = (hold == 0);
    @(posedge clock); #1;
    // Scramble inputs to show they are latched at acceptance.
    in_valid = 1'b0;
    in_funct3 = 3'b000;
    in_csr_addr = 12'hABC;
    in_rs1_val = 32'hBAD0BAD0;
    in_rs1_idx = 5'd31;
    in_rd_idx = 5'd31;
    check_output("read_addr", csr_r_addr, addr);
    check_output("busy_ready", in_ready, 0);
    check_output("read_we", w_enable, 0);
    @(posedge clock); #1;
    check_output("w_enable", w_enable, exp_we);
    if (exp_we) begin
      check_output("w_addr", csr_w_addr, addr);
      check_output("w_val", csr_w_val, exp_wval);
    end
    check_output("write_raddr", csr_r_addr, 0);
    check_output("write_valid", out_valid, 0);
    @(posedge clock); #1;
    check_output("resp_valid", out_valid, 1);
    check_output("resp_rd", out_rd_idx, rd);
    check_output("resp_rdval", out_rd_val, exp_rdval);
    check_output("resp_illegal", out_illegal, exp_ill);
    check_output("resp_we", w_enable, 0);
    check_output("resp_wval", csr_w_val, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      check_output("hold_valid", out_valid, 1);
      check_output("hold_rdval", out_rd_val, exp_rdval);
      check_output("hold_rd", out_rd_idx, rd);
      check_output("hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    check_output("done_valid", out_valid, 0);
    check_output("done_ready", in_ready, 1);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    check_output("rst_in_ready", in_ready, 1);
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_w_enable", w_enable, 0);
    check_output("rst_r_addr", csr_r_addr, 0);
    check_output("rst_w_addr", csr_w_addr, 0);
    check_output("rst_w_val", csr_w_val, 0);
    check_output("rst_rd_val", out_rd_val, 0);
    check_output("rst_illegal", out_illegal, 0);
    check_output("rst_op_count", op_count, 0);

    // CSRRW
    preload(12'h300, 32'hDEADBEEF);
    apply_stimulus(3'b001, 12'h300, 32'h12345678, 5'd7, 5'd5, 1, 32'h12345678, 32'hDEADBEEF, 0, 0);
    check_output("rw_mem", csr_mem[12'h300], 32'h12345678);
    check_output("rw_count", op_count, 1);

    // CSRRS then CSRRC
    preload(12'h301, 32'h000000F0);
    apply_stimulus(3'b010, 12'h301, 32'h0000000F, 5'd3, 5'd6, 1, 32'h000000FF, 32'h000000F0, 0, 0);
    apply_stimulus(3'b011, 12'h301, 32'h000000F0, 5'd4, 5'd7, 1, 32'h0000000F, 32'h000000FF, 0, 0);
    check_output("rc_mem", csr_mem[12'h301], 32'h0000000F);
    check_output("rsrc_count", op_count, 3);

    // No-write forms and immediates
    wc_snap = w_count;
    apply_stimulus(3'b010, 12'h300, 32'hFFFFFFFF, 5'd0, 5'd8, 0, 32'h0, 32'h12345678, 0, 0);
    apply_stimulus(3'b111, 12'h300, 32'hFFFFFFFF, 5'd0, 5'd8, 0, 32'h0, 32'h12345678, 0, 0);
    check_output("nowrite_count", w_count, wc_snap);
    apply_stimulus(3'b101, 12'h301, 32'h0000AAAA, 5'd0, 5'd9, 1, 32'h0, 32'h0000000F, 0, 0);
    apply_stimulus(3'b110, 12'h301, 32'hFFFF0000, 5'd31, 5'd10, 1, 32'h0000001F, 32'h0, 0, 0);
    check_output("rsi_mem", csr_mem[12'h301], 32'h0000001F);
    check_output("imm_count", op_count, 7);

    // Illegal cases
    preload(12'hC00, 32'h00000055);
    wc_snap = w_count;
    apply_stimulus(3'b100, 12'h300, 32'h1, 5'd1, 5'd11, 0, 32'h0, 32'h0, 1, 0);
    apply_stimulus(3'b001, 12'hC00, 32'h1, 5'd1, 5'd12, 0, 32'h0, 32'h0, 1, 0);
    check_output("illegal_count", op_count, 7);
    apply_stimulus(3'b010, 12'hC00, 32'h1, 5'd0, 5'd13, 0, 32'h0, 32'h00000055, 0, 0);
    check_output("illegal_nowrite", w_count, wc_snap);
    check_output("ro_mem", csr_mem[12'hC00], 32'h00000055);
    check_output("ro_count", op_count, 8);

    // Back-pressure then back-to-back op
    apply_stimulus(3'b010, 12'h300, 32'h0, 5'd0, 5'd14, 0, 32'h0, 32'h12345678, 0, 10);
    apply_stimulus(3'b001, 12'h300, 32'hA5A5A5A5, 5'd2, 5'd15, 1, 32'hA5A5A5A5, 32'h12345678, 0, 0);
    check_output("bp_count", op_count, 10);

    // Reset during READ
    preload(12'h302, 32'h11111111);
    wc_snap = w_count;
    in_valid = 1'b1;
    in_funct3 = 3'b001;
    in_csr_addr = 12'h302;
    in_rs1_val = 32'h22222222;
    in_rs1_idx = 5'd1;
    in_rd_idx = 5'd3;
    @(posedge clock); #1;
    in_valid = 1'b0;
    check_output("mid_read_addr", csr_r_addr, 12'h302);
    reset = 1'b0;
    @(posedge clock); #1;
    check_output("mid_rst_we", w_enable, 0);
    check_output("mid_rst_valid", out_valid, 0);
    check_output("mid_rst_count", op_count, 0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check_output("post_rst_we", w_enable, 0);
      check_output("post_rst_valid", out_valid, 0);
      check_output("post_rst_ready", in_ready, 1);
    end
    check_output("post_rst_wcount", w_count, wc_snap);
    check_output("post_rst_mem", csr_mem[12'h302], 32'h11111111);

    // op_count wrap
    force dut.op_count = 32'hFFFFFFFE;
    #1;
    release dut.op_count;
    apply_stimulus(3'b010, 12'h302, 32'h0, 5'd0, 5'd4, 0, 32'h0, 32'h11111111, 0, 0);
    check_output("wrap_pre", op_count, 32'hFFFFFFFF);
    apply_stimulus(3'b010, 12'h302, 32'h0, 5'd0, 5'd4, 0, 32'h0, 32'h11111111, 0, 0);
    check_output("wrap_zero", op_count, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
